edge_event_counter: RTL and testbench

Multi-channel, parametrised edge detector and event counter. Each channel synchronises an asynchronous input into the clk domain, detects rising and falling transitions, and counts rises, falls and total edges. Optional saturation and a snapshot handshake allow software or bench logic to read coherent counts. Used as the reusable successor of ad-hoc posedge/negedge counting in simulation and in synthesizable monitors.

---
 rtl/edge_event_counter.sv | 154 +++++++++++++++
 tb/tb_edge_event_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_counter.sv
// Multi-channel edge detector and rise/fall/total event counter with
// per-channel clear, sticky overflow and a coherent snapshot port.
module edge_event_counter #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SATURATE    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       sig_in,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       clear,
    input  logic                      snap_req,
    output logic [CHANNELS-1:0]       rise_pulse,
    output logic [CHANNELS-1:0]       fall_pulse,
    output logic [CHANNELS*CNT_W-1:0] rise_count,
    output logic [CHANNELS*CNT_W-1:0] fall_count,
    output logic [CHANNELS*CNT_W-1:0] any_count,
    output logic [CHANNELS-1:0]       overflow,
    output logic                      snap_valid,
    output logic [CHANNELS*CNT_W-1:0] snap_rise,
    output logic [CHANNELS*CNT_W-1:0] snap_fall,
    output logic [CHANNELS*CNT_W-1:0] snap_any
);

    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [CHANNELS-1:0][CNT_W-1:0] cnt_arr_t;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_s_c;
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] armed_q, armed_d;
    logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    cnt_arr_t            rise_cnt_q, rise_cnt_d;
    cnt_arr_t            fall_cnt_q, fall_cnt_d;
    cnt_arr_t            any_cnt_q, any_cnt_d;
    cnt_arr_t            snap_rise_q, snap_fall_q, snap_any_q;
    logic                snap_valid_q;
    logic [CNT_W:0]      inc_edge, inc_any;

    // Returns {overflow, next value}; overflow flags any increment past max.
    function automatic logic [CNT_W:0] incr(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] r;
        if (v == CNT_MAX) begin
            r = {1'b1, (SATURATE != 0) ? CNT_MAX : CNT_W'(0)};
        end else begin
            r = {1'b0, v + CNT_W'(1)};
        end
        return r;
    endfunction

    assign sync_s_c = sync_q[SYNC_STAGES-1];

    always_comb begin
        arm_cnt_d  = arm_cnt_q;
        armed_d    = armed_q;
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        any_cnt_d  = any_cnt_q;
        ovf_d      = ovf_q;
        inc_edge   = '0;
        inc_any    = '0;

        // Arm once the synchroniser output reflects post-reset input.
        if (arm_cnt_q != ARM_W'(SYNC_STAGES)) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end else begin
            armed_d = '1;
        end

        rise_d = sync_s_c & ~prev_q & armed_q;
        fall_d = ~sync_s_c & prev_q & armed_q;

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            inc_any = incr(any_cnt_q[i]);
            if (clear[i]) begin
                rise_cnt_d[i] = '0;
                fall_cnt_d[i] = '0;
                any_cnt_d[i]  = '0;
                ovf_d[i]      = 1'b0;
            end else if (enable && rise_d[i]) begin
                inc_edge      = incr(rise_cnt_q[i]);
                rise_cnt_d[i] = inc_edge[CNT_W-1:0];
                any_cnt_d[i]  = inc_any[CNT_W-1:0];
                ovf_d[i]      = ovf_q[i] | inc_edge[CNT_W] | inc_any[CNT_W];
            end else if (enable && fall_d[i]) begin
                inc_edge      = incr(fall_cnt_q[i]);
                fall_cnt_d[i] = inc_edge[CNT_W-1:0];
                any_cnt_d[i]  = inc_any[CNT_W-1:0];
                ovf_d[i]      = ovf_q[i] | inc_edge[CNT_W] | inc_any[CNT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
            prev_q       <= '0;
            armed_q      <= '0;
            arm_cnt_q    <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            ovf_q        <= '0;
            rise_cnt_q   <= '0;
            fall_cnt_q   <= '0;
            any_cnt_q    <= '0;
            snap_rise_q  <= '0;
            snap_fall_q  <= '0;
            snap_any_q   <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            sync_q[0] <= sig_in;
            for (int unsigned j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
            prev_q     <= sync_s_c;
            armed_q    <= armed_d;
            arm_cnt_q  <= arm_cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            ovf_q      <= ovf_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            any_cnt_q  <= any_cnt_d;
            // Snapshot takes the pre-update, pre-clear counter values.
            if (snap_req) begin
                snap_rise_q <= rise_cnt_q;
                snap_fall_q <= fall_cnt_q;
                snap_any_q  <= any_cnt_q;
            end
            snap_valid_q <= snap_req;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign rise_count = rise_cnt_q;
    assign fall_count = fall_cnt_q;
    assign any_count  = any_cnt_q;
    assign overflow   = ovf_q;
    assign snap_valid = snap_valid_q;
    assign snap_rise  = snap_rise_q;
    assign snap_fall  = snap_fall_q;
    assign snap_any   = snap_any_q;

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed bench for edge_event_counter: a wrapping and a saturating
// instance (4 channels, 4-bit counters) driven from shared inputs.
module tb_edge_event_counter;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] sig_in;
    logic          enable;
    logic [CH-1:0] clear;
    logic          snap_req;

    logic [CH-1:0]    rise_pulse, fall_pulse, overflow;
    logic [CH*CW-1:0] rise_count, fall_count, any_count;
    logic             snap_valid;
    logic [CH*CW-1:0] snap_rise, snap_fall, snap_any;

    logic [CH-1:0]    s_rise_pulse, s_fall_pulse, s_overflow;
    logic [CH*CW-1:0] s_rise_count, s_fall_count, s_any_count;
    logic             s_snap_valid;
    logic [CH*CW-1:0] s_snap_rise, s_snap_fall, s_snap_any;

    int n_checks = 0;
    int n_fail   = 0;
    int rp_cnt0  = 0;
    int fp_cnt0  = 0;
    int rp_any   = 0;

    typedef struct {
        logic [CH-1:0]    sig;
        logic             en;
        logic [CH*CW-1:0] er;
        logic [CH*CW-1:0] ef;
        logic [CH*CW-1:0] ea;
        logic [CH-1:0]    eo;
    } vec_t;

    vec_t vecs [7];

    edge_event_counter #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(2), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable), .clear(clear),
        .snap_req(snap_req), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .rise_count(rise_count), .fall_count(fall_count), .any_count(any_count),
        .overflow(overflow), .snap_valid(snap_valid), .snap_rise(snap_rise),
        .snap_fall(snap_fall), .snap_any(snap_any)
    );

    edge_event_counter #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(2), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable), .clear(clear),
        .snap_req(snap_req), .rise_pulse(s_rise_pulse), .fall_pulse(s_fall_pulse),
        .rise_count(s_rise_count), .fall_count(s_fall_count), .any_count(s_any_count),
        .overflow(s_overflow), .snap_valid(s_snap_valid), .snap_rise(s_snap_rise),
        .snap_fall(s_snap_fall), .snap_any(s_snap_any)
    );

    always #5 clk = ~clk;

    // Pulse tallies; readers sample them #1 after a negedge.
    always @(negedge clk) begin
        if (rise_pulse[0]) rp_cnt0++;
        if (fall_pulse[0]) fp_cnt0++;
        rp_any += $countones(rise_pulse);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [CH-1:0] s);
        @(negedge clk);
        rst = 1'b1; sig_in = s; clear = '0; snap_req = 1'b0; enable = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(6);
    endtask

    task automatic toggle_ch(input int ch, input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            sig_in[ch] = 1'b1;
            cycles(hold);
            sig_in[ch] = 1'b0;
            cycles(hold);
        end
    endtask

    initial begin
        int   rp0, fp0, rpa;
        bit   seen;
        vecs[0] = '{4'b0001, 1'b1, 16'h0001, 16'h0000, 16'h0001, 4'h0};
        vecs[1] = '{4'b0000, 1'b1, 16'h0001, 16'h0001, 16'h0002, 4'h0};
        vecs[2] = '{4'b0011, 1'b1, 16'h0012, 16'h0001, 16'h0013, 4'h0};
        vecs[3] = '{4'b0010, 1'b1, 16'h0012, 16'h0002, 16'h0014, 4'h0};
        vecs[4] = '{4'b1110, 1'b0, 16'h0012, 16'h0002, 16'h0014, 4'h0};
        vecs[5] = '{4'b0110, 1'b1, 16'h0012, 16'h1002, 16'h1014, 4'h0};
        vecs[6] = '{4'b0000, 1'b1, 16'h0012, 16'h1112, 16'h1124, 4'h0};

        rst = 1'b1; sig_in = '0; enable = 1'b1; clear = '0; snap_req = 1'b0;
        cycles(3);
        check("reset_rise_count", 32'(rise_count), 32'h0);
        check("reset_any_count", 32'(any_count), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
        check("reset_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
        check("reset_snap", 32'({snap_valid, snap_rise}), 32'h0);

        // Basic toggle on ch0: 5 periods of 5 high / 5 low.
        do_reset('0);
        #1; rp0 = rp_cnt0; fp0 = fp_cnt0;
        toggle_ch(0, 5, 5);
        cycles(5);
        #1;
        check("t1_rise_pulses", 32'(rp_cnt0 - rp0), 32'd5);
        check("t1_fall_pulses", 32'(fp_cnt0 - fp0), 32'd5);
        check("t1_rise_count", 32'(rise_count), 32'h0005);
        check("t1_fall_count", 32'(fall_count), 32'h0005);
        check("t1_any_count", 32'(any_count), 32'h000A);
        check("t1_overflow", 32'(overflow), 32'h0);

        // Table-driven multi-channel vectors, including enable=0 hold.
        do_reset('0);
        for (int i = 0; i < 7; i++) begin
            sig_in = vecs[i].sig;
            enable = vecs[i].en;
            cycles(5);
            check($sformatf("vec%0d_rise", i), 32'(rise_count), 32'(vecs[i].er));
            check($sformatf("vec%0d_fall", i), 32'(fall_count), 32'(vecs[i].ef));
            check($sformatf("vec%0d_any", i), 32'(any_count), 32'(vecs[i].ea));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].eo));
        end

        // 17 rises on ch1 (ends high): saturate vs wrap.
        do_reset('0);
        for (int k = 0; k < 17; k++) begin
            sig_in[1] = 1'b1;
            cycles(4);
            if (k < 16) begin
                sig_in[1] = 1'b0;
                cycles(4);
            end
        end
        cycles(4);
        check("sat_rise", 32'(s_rise_count), 32'h00F0);
        check("sat_any", 32'(s_any_count), 32'h00F0);
        check("sat_fall", 32'(s_fall_count), 32'h00F0);
        check("sat_ovf", 32'(s_overflow), 32'h2);
        check("wrap_rise", 32'(rise_count), 32'h0010);
        check("wrap_fall", 32'(fall_count), 32'h0000);
        check("wrap_any", 32'(any_count), 32'h0010);
        check("wrap_ovf", 32'(overflow), 32'h2);
        clear = 4'b0010;
        cycles(1);
        clear = '0;
        check("clr_counts", 32'({rise_count, any_count}), 32'h0);
        check("clr_ovf", 32'(overflow), 32'h0);

        // Inputs high through reset release are never counted as rises.
        @(negedge clk);
        rst = 1'b1; sig_in = 4'hF;
        cycles(2);
        #1; rpa = rp_any;
        @(negedge clk);
        rst = 1'b0;
        cycles(10);
        #1;
        check("hi_rst_no_rise_pulse", 32'(rp_any - rpa), 32'd0);
        check("hi_rst_rise_count", 32'(rise_count), 32'h0);
        sig_in = 4'b1011;
        cycles(5);
        check("hi_rst_fall2", 32'(fall_count), 32'h0100);
        check("hi_rst_any2", 32'(any_count), 32'h0100);
        check("hi_rst_rise_after", 32'(rise_count), 32'h0);

        // Clear held across the 4th rise: pulse emitted, count discarded.
        do_reset('0);
        toggle_ch(0, 3, 4);
        check("pre_clr_rise", 32'(rise_count), 32'h0003);
        clear = 4'b0001;
        sig_in[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (rise_pulse[0]) seen = 1'b1;
        end
        check("clr_edge_pulse_seen", 32'(seen), 32'd1);
        cycles(1);
        clear = '0;
        cycles(2);
        check("clr_edge_rise", 32'(rise_count), 32'h0);
        check("clr_edge_any", 32'(any_count), 32'h0);

        // Snapshot with simultaneous clear, then back-to-back request.
        do_reset('0);
        toggle_ch(0, 6, 4);
        check("pre_snap_rise", 32'(rise_count), 32'h0006);
        snap_req = 1'b1; clear = 4'b0001;
        cycles(1);
        check("snap_valid_1", 32'(snap_valid), 32'd1);
        check("snap_rise_6", 32'(snap_rise), 32'h0006);
        check("snap_any_12", 32'(snap_any), 32'h000C);
        check("live_rise_cleared", 32'(rise_count), 32'h0);
        clear = '0;
        cycles(1);
        check("snap_valid_b2b", 32'(snap_valid), 32'd1);
        check("snap_rise_b2b", 32'(snap_rise), 32'h0);
        snap_req = 1'b0;
        cycles(1);
        check("snap_valid_drop", 32'(snap_valid), 32'd0);
        check("snap_hold", 32'(snap_fall), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
